// File: rtl/seq_detect_ctrl.sv
// Configurable serial pattern detector: config over valid/ready, Mealy match pulse, counts to a target.
// y is combinational on the completing bit; cfg_ready is low only while a run is in progress.
module seq_detect_ctrl #(
    parameter int PW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [PW-1:0] cfg_pattern,
    input  logic [3:0]    cfg_len,
    input  logic          cfg_overlap,
    input  logic [CW-1:0] cfg_target,
    input  logic          start,
    input  logic          abort,
    input  logic          x,
    input  logic          x_valid,
    output logic          y,
    output logic [CW-1:0] match_cnt,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    localparam logic [3:0] LP_PW    = 4'(PW);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [PW-1:0] r_pattern;
    logic [3:0]    r_len;
    logic          r_overlap;
    logic [CW-1:0] r_target;
    logic [PW-1:0] r_window;
    logic [3:0]    r_bits_seen;
    logic [CW-1:0] r_match_cnt;

    logic          w_running;
    logic          w_cfg_hs;
    logic          w_start_go;
    logic [3:0]    w_len_clamped;
    logic [PW-1:0] w_shifted;
    logic [PW-1:0] w_mask;
    logic          w_enough;
    logic          w_match;
    logic [CW-1:0] w_cnt_inc;
    logic [3:0]    w_bits_inc;
    logic          w_hit_target;

    assign w_running  = (r_state == ST_RUN);
    assign w_cfg_hs   = cfg_valid & cfg_ready;
    // A config handshake wins over start in the same cycle; start is re-sampled next cycle.
    assign w_start_go = start & ~w_cfg_hs & ((r_state == ST_ARMED) | (r_state == ST_DONE));

    always_comb begin
        w_len_clamped = cfg_len;
        if (cfg_len == 4'd0) begin
            w_len_clamped = 4'd1;
        end else if (cfg_len > LP_PW) begin
            w_len_clamped = LP_PW;
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PW; i++) begin
            if (4'(i) < r_len) begin
                w_mask[i] = 1'b1;
            end
        end
    end

    assign w_shifted    = {r_window[PW-2:0], x};
    assign w_enough     = ({1'b0, r_bits_seen} + 5'd1) >= {1'b0, r_len};
    assign w_match      = w_running & x_valid & w_enough &
                          ((w_shifted & w_mask) == (r_pattern & w_mask));
    assign w_cnt_inc    = (&r_match_cnt) ? r_match_cnt : r_match_cnt + CW'(1);
    assign w_bits_inc   = (r_bits_seen == LP_PW) ? r_bits_seen : r_bits_seen + 4'd1;
    assign w_hit_target = w_match & (r_target != '0) & (w_cnt_inc == r_target);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cfg_hs) w_state_nxt = ST_ARMED;
            end
            ST_ARMED, ST_DONE: begin
                if (w_cfg_hs) begin
                    w_state_nxt = ST_ARMED;
                end else if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_ARMED;
                end else if (w_hit_target) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= 1'b0;
            r_target  <= '0;
        end else if (w_cfg_hs) begin
            r_pattern <= cfg_pattern;
            r_len     <= w_len_clamped;
            r_overlap <= cfg_overlap;
            r_target  <= cfg_target;
        end
    end

    // Non-overlap mode restarts the bit count so the next match needs len fresh bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_window    <= '0;
            r_bits_seen <= '0;
            r_match_cnt <= '0;
        end else if (w_start_go) begin
            r_window    <= '0;
            r_bits_seen <= '0;
            r_match_cnt <= '0;
        end else if (w_running && x_valid) begin
            r_window    <= w_shifted;
            r_bits_seen <= (w_match && !r_overlap) ? 4'd0 : w_bits_inc;
            if (w_match) begin
                r_match_cnt <= w_cnt_inc;
            end
        end
    end

    assign y         = w_match;
    assign match_cnt = r_match_cnt;
    assign busy      = w_running;
    assign done      = (r_state == ST_DONE);
    assign cfg_ready = ~w_running;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: a vector table plus hand-written multi-cycle sequences.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_target;
    logic       start;
    logic       abort;
    logic       x;
    logic       x_valid;
    logic       y;
    logic [7:0] match_cnt;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit         newcfg;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ov;
        logic [7:0] tgt;
        logic       xv;
        logic       x;
        logic       ey;
        logic [7:0] ecnt;
        logic       ebusy;
        logic       edone;
    } vec_t;

    vec_t tv[$];

    bit         pend_cfg;
    logic [7:0] pend_pat;
    logic [3:0] pend_len;
    logic       pend_ov;
    logic [7:0] pend_tgt;

    seq_detect_ctrl #(.PW(8), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
        .start(start), .abort(abort),
        .x(x), .x_valid(x_valid),
        .y(y), .match_cnt(match_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] t);
        pend_cfg = 1'b1;
        pend_pat = p;
        pend_len = l;
        pend_ov  = o;
        pend_tgt = t;
    endtask

    task automatic add_bit(input logic b, input logic ey, input logic [7:0] ecnt,
                           input logic eb, input logic ed);
        vec_t v;
        v.newcfg = pend_cfg;
        v.pat = pend_pat; v.len = pend_len; v.ov = pend_ov; v.tgt = pend_tgt;
        v.xv = 1'b1; v.x = b; v.ey = ey; v.ecnt = ecnt; v.ebusy = eb; v.edone = ed;
        tv.push_back(v);
        pend_cfg = 1'b0;
    endtask

    task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] t);
        x_valid = 1'b0;
        if (busy) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end
        cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t;
        cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drive one cycle, check y mid-cycle, then check registered outputs after the edge.
    task automatic step(input string name, input logic xv, input logic xb, input logic ey);
        x_valid = xv;
        x = xb;
        #2;
        chk({name, "_y"}, y, ey);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] fpat;
        int pulses;

        rst = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; cfg_target = '0; start = 1'b0; abort = 1'b0;
        x = 1'b1; x_valid = 1'b1;
        pend_cfg = 1'b0; pend_pat = '0; pend_len = '0; pend_ov = 1'b0; pend_tgt = '0;

        // Vector table
        add_cfg(8'h35, 4'd6, 1'b1, 8'd0);
        add_bit(1, 0, 0, 1, 0); add_bit(1, 0, 0, 1, 0); add_bit(0, 0, 0, 1, 0);
        add_bit(1, 0, 0, 1, 0); add_bit(0, 0, 0, 1, 0); add_bit(1, 1, 1, 1, 0);
        add_bit(0, 0, 1, 1, 0); add_bit(1, 0, 1, 1, 0);
        add_cfg(8'h05, 4'd3, 1'b1, 8'd0);
        add_bit(1, 0, 0, 1, 0); add_bit(0, 0, 0, 1, 0); add_bit(1, 1, 1, 1, 0);
        add_bit(0, 0, 1, 1, 0); add_bit(1, 1, 2, 1, 0);
        add_cfg(8'h05, 4'd3, 1'b0, 8'd0);
        add_bit(1, 0, 0, 1, 0); add_bit(0, 0, 0, 1, 0); add_bit(1, 1, 1, 1, 0);
        add_bit(0, 0, 1, 1, 0); add_bit(1, 0, 1, 1, 0);
        add_cfg(8'h03, 4'd2, 1'b1, 8'd3);
        add_bit(1, 0, 0, 1, 0); add_bit(1, 1, 1, 1, 0); add_bit(1, 1, 2, 1, 0);
        add_bit(1, 1, 3, 0, 1); add_bit(1, 0, 3, 0, 1);
        add_cfg(8'h01, 4'd0, 1'b1, 8'd0);
        add_bit(1, 1, 1, 1, 0); add_bit(0, 0, 1, 1, 0); add_bit(1, 1, 2, 1, 0);
        add_bit(1, 1, 3, 1, 0);
        // Length 12 clamps to 8; non-overlap needs 8 fresh bits for the second hit.
        fpat = 8'hA5;
        add_cfg(fpat, 4'd12, 1'b0, 8'd0);
        for (int i = 0; i < 16; i++) begin
            add_bit(fpat[7 - (i % 8)], (i == 7 || i == 15),
                    (i < 7) ? 8'd0 : ((i < 15) ? 8'd1 : 8'd2), 1, 0);
        end

        // Reset state, checked while reset is held with a live-looking input
        #3;
        chk("rst_y", y, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        x_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("idle_start_ignored", busy, 0);

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].newcfg) load_cfg(tv[i].pat, tv[i].len, tv[i].ov, tv[i].tgt);
            step($sformatf("v%0d", i), tv[i].xv, tv[i].x, tv[i].ey);
            chk($sformatf("v%0d_cnt", i), match_cnt, tv[i].ecnt);
            chk($sformatf("v%0d_busy", i), busy, tv[i].ebusy);
            chk($sformatf("v%0d_done", i), done, tv[i].edone);
        end
        x_valid = 1'b0;

        // x_valid gaps with junk data while invalid
        load_cfg(8'h05, 4'd3, 1'b1, 8'd0);
        pulses = 0;
        for (int b = 0; b < 3; b++) begin
            for (int g = 0; g < 3; g++) begin
                x_valid = 1'b0; x = 1'($urandom_range(0, 1));
                #2; if (y) pulses++;
                @(posedge clk); #1;
            end
            x_valid = 1'b1; x = (b != 1);
            #2; if (y) pulses++;
            chk($sformatf("gap_bit%0d_y", b), y, (b == 2));
            @(posedge clk); #1;
        end
        x_valid = 1'b0;
        chk("gap_pulses", pulses, 1);
        chk("gap_cnt", match_cnt, 1);

        // Target reached, DONE behaviour, handshake from DONE, restart
        load_cfg(8'h03, 4'd2, 1'b1, 8'd3);
        for (int i = 0; i < 4; i++) step($sformatf("tgt%0d", i), 1, 1, (i != 0));
        chk("tgt_done", done, 1);
        chk("tgt_cfg_ready", cfg_ready, 1);
        step("tgt_after", 1, 1, 0);
        chk("tgt_cnt_hold", match_cnt, 3);
        x_valid = 1'b0;
        cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        chk("done_hs_clears", done, 0);
        chk("done_hs_armed", busy, 0);
        chk("done_hs_cnt_hold", match_cnt, 3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("restart_busy", busy, 1);
        chk("restart_cnt", match_cnt, 0);

        // Abort coinciding with the target-reaching match
        load_cfg(8'h03, 4'd2, 1'b1, 8'd2);
        step("ab0", 1, 1, 0);
        step("ab1", 1, 1, 1);
        abort = 1'b1;
        step("ab2", 1, 1, 1);
        abort = 1'b0;
        x_valid = 1'b0;
        chk("ab_cnt", match_cnt, 2);
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("ab_outside_run", match_cnt, 2);

        // Config and start in the same cycle: start only taken next cycle
        cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_overlap = 1'b1; cfg_target = 8'd0;
        cfg_valid = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        chk("cs_same_cycle_busy", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("cs_next_busy", busy, 1);
        chk("cs_next_cnt", match_cnt, 0);
        step("cs_newcfg", 1, 1, 1);

        // Config offered while busy is not taken
        chk("busy_cfg_ready", cfg_ready, 0);
        x_valid = 1'b0;
        cfg_pattern = 8'h00; cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        step("busy_keep1", 1, 1, 1);
        step("busy_keep0", 1, 0, 0);

        // Asynchronous reset mid-run after two matches
        load_cfg(8'h03, 4'd2, 1'b1, 8'd0);
        step("rr0", 1, 1, 0);
        step("rr1", 1, 1, 1);
        step("rr2", 1, 1, 1);
        chk("rr_cnt_pre", match_cnt, 2);
        x_valid = 1'b1; x = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_y", y, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_cnt", match_cnt, 0);
        chk("arst_cfg_ready", cfg_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        x_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("arst_start_ignored", busy, 0);
        step("arst_no_y", 1, 1, 0);
        x_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
